// File: rtl/count_report_tx.sv
// Frequency-counter report transmitter: reads each result word through the
// ch_sel/ch_data mux and sends it as a 7-byte frame on an 8N1 UART line.
//
// Ports:
//   clk_ocxo  reference clock, the only clock
//   rst       asynchronous active-high reset
//   EN        enable; low aborts a run once the byte in flight completes
//   start     report request, sampled only while idle
//   ch_data   result word selected by ch_sel (external mux)
//   ch_sel    index of the word being read
//   txd       UART serial output, idles high
//   busy      high from start acceptance until return to idle
//   done      one-cycle pulse after the last stop bit of the last frame
module count_report_tx #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int BIT_CNT     = 29,
    parameter int NUM_CH      = 31
) (
    input  logic               clk_ocxo,
    input  logic               rst,
    input  logic               EN,
    input  logic               start,
    input  logic [BIT_CNT-1:0] ch_data,
    output logic [4:0]         ch_sel,
    output logic               txd,
    output logic               busy,
    output logic               done
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int CW  = $clog2(DIV);

    localparam logic [CW-1:0] BAUD_TOP = CW'(DIV - 1);
    localparam logic [4:0]    LAST_CH  = 5'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        NEXT
    } state_t;

    state_t        state;
    logic [31:0]   word;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic          abort_pend;

    logic [7:0]    chk;
    logic [7:0]    cur_byte;
    logic          tx_bit;
    logic          bit_wrap;
    logic          byte_end;

    // The frame is derived from the latched word and the index, which both
    // hold steady for the whole frame, so no separate frame buffer is kept.
    always_comb begin
        chk = {3'b000, ch_sel} ^ word[31:24] ^ word[23:16]
            ^ word[15:8] ^ word[7:0];
        cur_byte = chk;
        case (byte_idx)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = {3'b000, ch_sel};
            3'd2:    cur_byte = word[31:24];
            3'd3:    cur_byte = word[23:16];
            3'd4:    cur_byte = word[15:8];
            3'd5:    cur_byte = word[7:0];
            default: cur_byte = chk;
        endcase
    end

    // bit_idx 0 is the start bit, 1..8 the data bits LSB first, 9 the stop
    // bit; bit_idx 8 maps to data bit 7 through the 3-bit wrap of 0-1.
    always_comb begin
        tx_bit = cur_byte[bit_idx[2:0] - 3'd1];
        if (bit_idx == 4'd0) begin
            tx_bit = 1'b0;
        end else if (bit_idx == 4'd9) begin
            tx_bit = 1'b1;
        end
    end

    assign bit_wrap = (baud_cnt == BAUD_TOP);
    assign byte_end = bit_wrap && (bit_idx == 4'd9);

    // txd is registered from the current bit indices, so the line trails
    // the SEND bookkeeping by one clock; the extra clock overlaps NEXT.
    always_ff @(posedge clk_ocxo or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ch_sel     <= 5'd0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            word       <= 32'd0;
            baud_cnt   <= '0;
            bit_idx    <= 4'd0;
            byte_idx   <= 3'd0;
            abort_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (start && EN) begin
                        busy   <= 1'b1;
                        ch_sel <= 5'd0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    txd <= 1'b1;
                    if (!EN) begin
                        busy   <= 1'b0;
                        ch_sel <= 5'd0;
                        state  <= IDLE;
                    end else begin
                        word       <= 32'(ch_data);
                        baud_cnt   <= '0;
                        bit_idx    <= 4'd0;
                        byte_idx   <= 3'd0;
                        abort_pend <= 1'b0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    txd <= tx_bit;
                    if (!EN) begin
                        abort_pend <= 1'b1;
                    end
                    if (!bit_wrap) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (!byte_end) begin
                            bit_idx <= bit_idx + 4'd1;
                        end else begin
                            bit_idx <= 4'd0;
                            if (abort_pend || !EN) begin
                                busy   <= 1'b0;
                                ch_sel <= 5'd0;
                                state  <= IDLE;
                            end else if (byte_idx == 3'd6) begin
                                state <= NEXT;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                            end
                        end
                    end
                end
                NEXT: begin
                    txd <= 1'b1;
                    if (!EN) begin
                        busy   <= 1'b0;
                        ch_sel <= 5'd0;
                        state  <= IDLE;
                    end else if (ch_sel == LAST_CH) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        ch_sel <= 5'd0;
                        state  <= IDLE;
                    end else begin
                        ch_sel <= ch_sel + 5'd1;
                        state  <= LOAD;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_report_tx.sv
// Testbench for count_report_tx: a UART receiver decodes both DUT lines and
// compares each byte against frames queued when the stimulus was driven.
module tb_count_report_tx;

    localparam int DIV   = 10;
    localparam int FRAME = 70 * DIV + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, en_a, start_b, en_b;
    logic [28:0] data_a, data_b;
    logic [4:0]  sel_a, sel_b;
    logic        txd_a, busy_a, done_a;
    logic        txd_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q0[$];
    int exp_q1[$];
    int done_cnt_b = 0;

    always #5 clk = ~clk;

    count_report_tx #(
        .CLK_FREQ_HZ(1000000), .BAUD(100000), .BIT_CNT(29), .NUM_CH(1)
    ) u_one (
        .clk_ocxo(clk), .rst(rst), .EN(en_a), .start(start_a),
        .ch_data(data_a), .ch_sel(sel_a), .txd(txd_a),
        .busy(busy_a), .done(done_a)
    );

    count_report_tx #(
        .CLK_FREQ_HZ(1000000), .BAUD(100000), .BIT_CNT(29), .NUM_CH(31)
    ) u_multi (
        .clk_ocxo(clk), .rst(rst), .EN(en_b), .start(start_b),
        .ch_data(data_b), .ch_sel(sel_b), .txd(txd_b),
        .busy(busy_b), .done(done_b)
    );

    // External mux model for the multi-channel unit.
    assign data_b = 29'(32'(sel_b) * 3);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int lane, input int idx,
                              input logic [31:0] w, input logic [7:0] c);
        int b[7];
        b[0] = 'hA5;
        b[1] = idx;
        b[2] = int'(w[31:24]);
        b[3] = int'(w[23:16]);
        b[4] = int'(w[15:8]);
        b[5] = int'(w[7:0]);
        b[6] = int'(c);
        for (int i = 0; i < 7; i++) begin
            if (lane == 0) exp_q0.push_back(b[i]);
            else exp_q1.push_back(b[i]);
        end
    endtask

    task automatic got_byte(input int lane, input int v);
        int e;
        if (lane == 0) begin
            if (exp_q0.size() == 0) begin
                check("rx_unexpected_a", v, 32'hDEAD);
                return;
            end
            e = exp_q0.pop_front();
            check("rx_byte_a", v, e);
        end else begin
            if (exp_q1.size() == 0) begin
                check("rx_unexpected_b", v, 32'hDEAD);
                return;
            end
            e = exp_q1.pop_front();
            check("rx_byte_b", v, e);
        end
    endtask

    // 8N1 receiver, sampling each bit at its centre on falling edges.
    logic       line[2];
    logic       rx_act[2];
    int         rx_cnt[2];
    logic [7:0] rx_sh[2];

    assign line[0] = txd_a;
    assign line[1] = txd_b;

    initial begin
        for (int l = 0; l < 2; l++) begin
            rx_act[l] = 1'b0;
            rx_cnt[l] = 0;
            rx_sh[l]  = 8'h00;
        end
    end

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            int         c;
            int         n;
            logic [7:0] sh;
            c  = rx_cnt[l] + 1;
            sh = rx_sh[l];
            if (rst) begin
                rx_act[l] <= 1'b0;
            end else if (!rx_act[l]) begin
                if (line[l] == 1'b0) begin
                    rx_act[l] <= 1'b1;
                    rx_cnt[l] <= 0;
                end
            end else begin
                rx_cnt[l] <= c;
                if (c % DIV == DIV / 2) begin
                    n = c / DIV;
                    if (n == 0 && line[l]) begin
                        got_byte(l, -2);
                        rx_act[l] <= 1'b0;
                    end else if (n >= 1 && n <= 8) begin
                        sh[n-1] = line[l];
                        rx_sh[l] <= sh;
                    end else if (n == 9) begin
                        got_byte(l, line[l] ? int'(sh) : -1);
                        rx_act[l] <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    // One full single-channel run on the NUM_CH=1 unit.
    task automatic run_a(input int hold);
        int lat;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        lat = 0;
        check("busy_accept", 32'(busy_a), 1);
        check("sel_accept", 32'(sel_a), 0);
        check("txd_accept", 32'(txd_a), 1);
        @(negedge clk);
        lat++;
        check("txd_load", 32'(txd_a), 1);
        @(negedge clk);
        lat++;
        check("start_bit", 32'(txd_a), 0);
        if (hold != 0) data_a = 29'h1FFF_FFFF;
        while (!done_a && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, FRAME);
        check("busy_at_done", 32'(busy_a), 0);
        @(negedge clk);
        check("done_one_cycle", 32'(done_a), 0);
        check("frame_a_left", exp_q0.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        logic [28:0] data;
        logic [7:0]  chk;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        int low_cnt;

        vecs[0] = '{29'h0123_4567, 8'h00};
        vecs[1] = '{29'h1FFF_FFFF, 8'hE0};
        vecs[2] = '{29'h1000_0001, 8'h11};
        vecs[3] = '{29'h0ABC_DEF0, 8'h98};

        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        en_a = 1'b1;
        en_b = 1'b1;
        data_a = '0;
        repeat (3) @(negedge clk);
        check("rst_txd_a", 32'(txd_a), 1);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_done_a", 32'(done_a), 0);
        check("rst_sel_a", 32'(sel_a), 0);
        check("rst_txd_b", 32'(txd_b), 1);
        check("rst_busy_b", 32'(busy_b), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single-frame table.
        for (int i = 0; i < 4; i++) begin
            data_a = vecs[i].data;
            push_frame(0, 0, 32'(vecs[i].data), vecs[i].chk);
            run_a(0);
        end

        // Word latched in LOAD; later mux changes must not reach the frame.
        data_a = 29'h1;
        push_frame(0, 0, 32'h1, 8'h01);
        run_a(1);

        // Full 31-channel run with a stray start during frame 3.
        for (int i = 0; i < 31; i++) begin
            push_frame(1, i, 32'(i * 3), 8'(i ^ (i * 3)));
        end
        base = done_cnt_b;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 30000) begin
            @(negedge clk);
            lat++;
            start_b = (lat == 3 * FRAME + 300);
            if (lat == 3 * FRAME + 300) check("sel_mid_f3", 32'(sel_b), 3);
        end
        start_b = 1'b0;
        check("multi_latency", lat, 31 * FRAME);
        check("multi_busy_end", 32'(busy_b), 0);
        check("multi_sel_end", 32'(sel_b), 0);
        repeat (50) @(negedge clk);
        check("multi_done_count", done_cnt_b - base, 1);
        check("multi_busy_idle", 32'(busy_b), 0);
        check("frame_b_left", exp_q1.size(), 0);

        // Abort mid byte 2 of frame 4.
        for (int i = 0; i < 4; i++) begin
            push_frame(1, i, 32'(i * 3), 8'(i ^ (i * 3)));
        end
        exp_q1.push_back('hA5);
        exp_q1.push_back(4);
        exp_q1.push_back(0);
        base = done_cnt_b;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 0;
        while (lat < 4 * FRAME + 2 + 20 * DIV + 50) begin
            @(negedge clk);
            lat++;
        end
        check("sel_abort_f4", 32'(sel_b), 4);
        en_b = 1'b0;
        while (busy_b && lat < 5 * FRAME) begin
            @(negedge clk);
            lat++;
        end
        check("abort_latency", lat, 4 * FRAME + 301);
        check("abort_sel", 32'(sel_b), 0);
        check("abort_txd", 32'(txd_b), 1);
        en_b = 1'b1;
        low_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (!txd_b) low_cnt++;
        end
        check("abort_line_idle", low_cnt, 0);
        check("abort_no_done", done_cnt_b - base, 0);
        check("abort_busy", 32'(busy_b), 0);
        check("abort_frames_left", exp_q1.size(), 0);

        // Asynchronous reset in the middle of a start bit.
        data_a = 29'h0ABC_DEF0;
        push_frame(0, 0, 32'h0ABC_DEF0, 8'h98);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        lat = 0;
        while (txd_a && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("pre_reset_start_bit", 32'(txd_a), 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_txd", 32'(txd_a), 1);
        check("async_rst_busy", 32'(busy_a), 0);
        check("async_rst_sel", 32'(sel_a), 0);
        exp_q0.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_txd", 32'(txd_a), 1);
        data_a = vecs[2].data;
        push_frame(0, 0, 32'(vecs[2].data), vecs[2].chk);
        run_a(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
